// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like memory port between instruction fetch
// and data access. Data goes first, then the fetch. Read data is latched per side.
// The pipeline stays stalled until every enabled request has completed.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch side
    input  logic              inst_en,
    input  logic [AW-1:0]     inst_addr,
    output logic [DW-1:0]     inst_rdata,
    // data side
    input  logic              data_en,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW/8-1:0]   data_wen,
    input  logic [DW-1:0]     data_wdata,
    output logic [DW-1:0]     data_rdata,
    // pipeline control
    output logic              cpu_stall,
    // memory bridge
    output logic              bus_req,
    output logic              bus_wr,
    output logic [AW-1:0]     bus_addr,
    output logic [DW/8-1:0]   bus_wstrb,
    output logic [DW-1:0]     bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DW-1:0]     bus_rdata
);

    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ADDR = 3'd1,
        D_DATA = 3'd2,
        I_ADDR = 3'd3,
        I_DATA = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            inst_done_q, inst_done_d;
    logic            data_done_q, data_done_d;
    logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DW-1:0]   data_rdata_q, data_rdata_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_wr_q, bus_wr_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [SW-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;

    // A side is still owed a result while it is enabled and not yet done.
    // Any transaction in flight also holds the pipeline.
    assign cpu_stall = (inst_en & ~inst_done_q)
                     | (data_en & ~data_done_q)
                     | (state_q != IDLE);

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_wdata  = bus_wdata_q;

    // Next-state: sequence data then fetch, latch responses, track done flags
    always_comb begin
        state_d      = state_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_wdata_d  = bus_wdata_q;

        // The pipeline advances on this edge, so the finished results are consumed.
        // A stall of 0 only happens in IDLE, so this never collides with setting a done flag.
        if (!cpu_stall) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Data first: it belongs to the older instruction in the pipe.
                if (data_en && !data_done_q) begin
                    state_d     = D_ADDR;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = data_addr;
                    bus_wr_d    = |data_wen;
                    bus_wstrb_d = data_wen;
                    bus_wdata_d = data_wdata;
                end else if (inst_en && !inst_done_q) begin
                    state_d     = I_ADDR;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = inst_addr;
                    bus_wr_d    = 1'b0;
                    bus_wstrb_d = '0;
                    bus_wdata_d = '0;
                end
            end
            // Once issued, a request is held until it is accepted, even if the enable drops.
            D_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = D_DATA;
                    bus_req_d = 1'b0;
                end
            end
            I_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = I_DATA;
                    bus_req_d = 1'b0;
                end
            end
            // A dropped enable means the request was flushed, so its response is discarded.
            D_DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                    if (data_en) begin
                        data_done_d = 1'b1;
                        if (!bus_wr_q) begin
                            data_rdata_d = bus_rdata;
                        end
                    end
                end
            end
            I_DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                    if (inst_en) begin
                        inst_done_d  = 1'b1;
                        inst_rdata_d = bus_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs; reset abandons any outstanding transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wstrb_q  <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. The memory side is driven cycle by cycle.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [31:0] data_addr;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_addr(data_addr), .data_wen(data_wen),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // advance one clock; sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_en = 0; inst_addr = 0; data_en = 0; data_addr = 0;
        data_wen = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req act=%b exp=0", bus_req); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall act=%b exp=0", cpu_stall); end
        n_cmp++; if (inst_rdata !== 32'h0) begin n_err++; $display("FAIL reset_inst_rdata act=%h exp=0", inst_rdata); end
        n_cmp++; if (data_rdata !== 32'h0) begin n_err++; $display("FAIL reset_data_rdata act=%h exp=0", data_rdata); end
        n_cmp++; if ({bus_wr, bus_addr, bus_wstrb, bus_wdata} !== 69'h0) begin n_err++; $display("FAIL reset_bus_regs act=%b/%h/%b/%h exp=0", bus_wr, bus_addr, bus_wstrb, bus_wdata); end
        $display("txn reset: stall=%b bus_req=%b", cpu_stall, bus_req);
    endtask

    task automatic test_fetch();
        // cycle 0
        inst_en = 1; inst_addr = 32'hBFC0_0000;
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0 act=%b exp=1", cpu_stall); end
        tick(); // cycle 1
        n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL fetch_req_c1 act=%b exp=1", bus_req); end
        n_cmp++; if (bus_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL fetch_addr act=%h exp=bfc00000", bus_addr); end
        n_cmp++; if (bus_wr !== 1'b0) begin n_err++; $display("FAIL fetch_wr act=%b exp=0", bus_wr); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c1 act=%b exp=1", cpu_stall); end
        bus_addr_ok = 1;
        tick(); // cycle 2
        bus_addr_ok = 0;
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_c2 act=%b exp=0", bus_req); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c2 act=%b exp=1", cpu_stall); end
        bus_data_ok = 1; bus_rdata = 32'h3C08_0001;
        tick(); // cycle 3
        bus_data_ok = 0;
        n_cmp++; if (inst_rdata !== 32'h3C08_0001) begin n_err++; $display("FAIL fetch_rdata act=%h exp=3c080001", inst_rdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_c3 act=%b exp=0", cpu_stall); end
        $display("txn fetch: addr=bfc00000 rdata=%h", inst_rdata);
        inst_en = 0;
        tick();
    endtask

    task automatic test_load_and_fetch();
        data_en = 1; data_addr = 32'h8000_1000; data_wen = 4'b0000; data_wdata = 0;
        inst_en = 1; inst_addr = 32'hBFC0_0004;
        tick(); // c1: data goes first
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_1000) begin n_err++; $display("FAIL both_first_req act=%b/%h exp=1/80001000", bus_req, bus_addr); end
        n_cmp++; if (bus_wr !== 1'b0) begin n_err++; $display("FAIL both_load_wr act=%b exp=0", bus_wr); end
        bus_addr_ok = 1;
        tick(); // c2
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
        tick(); // c3
        bus_data_ok = 0;
        n_cmp++; if (data_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL both_data_rdata act=%h exp=11112222", data_rdata); end
        n_cmp++; if (cpu_stall !== 1'b1 || bus_req !== 1'b0) begin n_err++; $display("FAIL both_mid act=stall%b/req%b exp=1/0", cpu_stall, bus_req); end
        tick(); // c4: fetch second
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0004) begin n_err++; $display("FAIL both_second_req act=%b/%h exp=1/bfc00004", bus_req, bus_addr); end
        bus_addr_ok = 1;
        tick(); // c5
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3333_4444;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL both_stall_c5 act=%b exp=1", cpu_stall); end
        tick(); // c6
        bus_data_ok = 0;
        n_cmp++; if (inst_rdata !== 32'h3333_4444) begin n_err++; $display("FAIL both_inst_rdata act=%h exp=33334444", inst_rdata); end
        n_cmp++; if (data_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL both_data_hold act=%h exp=11112222", data_rdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL both_stall_c6 act=%b exp=0", cpu_stall); end
        tick(); // c7: done flags cleared, enables still high, so the stall returns
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL both_done_clear act=%b exp=1", cpu_stall); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL both_no_reissue act=%b exp=0", bus_req); end
        $display("txn load+fetch: data=%h inst=%h", data_rdata, inst_rdata);
        data_en = 0; inst_en = 0;
        tick();
    endtask

    task automatic test_store();
        data_en = 1; data_addr = 32'h8000_2000; data_wen = 4'b0011; data_wdata = 32'h0000_BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if (bus_req !== 1'b1 || bus_wr !== 1'b1 || bus_wstrb !== 4'b0011 ||
                bus_addr !== 32'h8000_2000 || bus_wdata !== 32'h0000_BEEF) begin
                n_err++;
                $display("FAIL store_stable_c%0d act=req%b wr%b strb%b %h %h exp=1 1 0011 80002000 0000beef",
                         c, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata);
            end
            bus_addr_ok = (c == 4);
        end
        tick(); // D_DATA
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL store_req_drop act=%b exp=0", bus_req); end
        tick();
        bus_data_ok = 0;
        n_cmp++; if (data_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL store_rdata_kept act=%h exp=11112222", data_rdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL store_stall act=%b exp=0", cpu_stall); end
        $display("txn store: addr=80002000 strb=0011 data_rdata=%h", data_rdata);
        data_en = 0; data_wen = 0;
        tick();
    endtask

    task automatic test_flush();
        data_en = 1; data_addr = 32'h8000_3000; data_wen = 0;
        inst_en = 1; inst_addr = 32'hBFC0_0008;
        tick(); // c1 D_ADDR
        bus_addr_ok = 1;
        tick(); // c2 D_DATA
        bus_addr_ok = 0;
        data_en = 0; // flushed
        tick(); // c3 still waiting
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL flush_stall_wait act=%b exp=1", cpu_stall); end
        bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
        tick(); // c4 IDLE
        bus_data_ok = 0;
        n_cmp++; if (data_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL flush_rdata act=%h exp=11112222", data_rdata); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL flush_fetch_pending act=%b exp=1", cpu_stall); end
        tick(); // c5 fetch issued
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0008) begin n_err++; $display("FAIL flush_fetch_req act=%b/%h exp=1/bfc00008", bus_req, bus_addr); end
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h5555_6666;
        tick(); // c7
        bus_data_ok = 0;
        n_cmp++; if (inst_rdata !== 32'h5555_6666 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL flush_fetch_done act=%h/%b exp=55556666/0", inst_rdata, cpu_stall); end
        // data side re-enabled: its done flag never set, so it is owed a result
        data_en = 1;
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL flush_data_done act=%b exp=1", cpu_stall); end
        $display("txn flush: data_rdata=%h inst_rdata=%h", data_rdata, inst_rdata);
        data_en = 0; inst_en = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        inst_en = 1; inst_addr = 32'hBFC0_000C;
        tick(); // I_ADDR
        bus_addr_ok = 1;
        tick(); // I_DATA
        bus_addr_ok = 0;
        rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req act=%b exp=0", bus_req); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rstmid_stall_en act=%b exp=1", cpu_stall); end
        n_cmp++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_addr act=%h exp=0", bus_addr); end
        inst_en = 0;
        #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall_idle act=%b exp=0", cpu_stall); end
        bus_data_ok = 1; bus_rdata = 32'hAAAA_AAAA;
        tick();
        bus_data_ok = 0;
        n_cmp++; if (inst_rdata !== 32'h0 || bus_req !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stray act=%h/%b/%b exp=0/0/0", inst_rdata, bus_req, cpu_stall); end
        $display("txn reset-mid: inst_rdata=%h stall=%b", inst_rdata, cpu_stall);
        tick();
    endtask

    task automatic test_back_to_back();
        int req_cycles = 0;
        inst_en = 1; inst_addr = 32'hBFC0_0010;
        tick(); // c1
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0010) begin n_err++; $display("FAIL b2b_req0 act=%b/%h exp=1/bfc00010", bus_req, bus_addr); end
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0000_00A0;
        tick(); // c3
        bus_data_ok = 0;
        n_cmp++; if (inst_rdata !== 32'h0000_00A0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL b2b_first act=%h/%b exp=000000a0/0", inst_rdata, cpu_stall); end
        tick(); // c4: pipeline advanced, next fetch presented
        inst_addr = 32'hBFC0_0014;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL b2b_nodup act=req%b/stall%b exp=0/1", bus_req, cpu_stall); end
        tick(); // c5
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0014) begin n_err++; $display("FAIL b2b_req1 act=%b/%h exp=1/bfc00014", bus_req, bus_addr); end
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0000_00B0;
        tick(); // c7
        bus_data_ok = 0;
        n_cmp++; if (inst_rdata !== 32'h0000_00B0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL b2b_second act=%h/%b exp=000000b0/0", inst_rdata, cpu_stall); end
        inst_en = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus_req === 1'b1) req_cycles++;
        end
        n_cmp++; if (req_cycles !== 0) begin n_err++; $display("FAIL b2b_extra_req act=%0d exp=0", req_cycles); end
        $display("txn back-to-back: last inst_rdata=%h", inst_rdata);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_and_fetch();
        test_store();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory port (req / addr_ok / data_ok handshake) between the datapath's instruction-fetch and data-access sides.
- Sequences the two requests, data first, and latches their read data.
- Drives a single pipeline stall until every request enabled this cycle has completed.
- Sits between the datapath (inst_addrF/inst_enF, mem_*M) and the memory bridge.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte strobe width is DW/8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst_en  in  1  fetch request; held with inst_addr while cpu_stall=1.
- inst_addr  in  AW  fetch address.
- inst_rdata  out  DW  latched fetch data.
- data_en  in  1  data request; held with the other data_* inputs while cpu_stall=1.
- data_addr  in  AW  data address.
- data_wen  in  DW/8  byte write enables; all zero means read.
- data_wdata  in  DW  store data.
- data_rdata  out  DW  latched load data.
- cpu_stall  out  1  freeze the pipeline.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_addr  out  AW  request address.
- bus_wstrb  out  DW/8  byte strobes.
- bus_wdata  out  DW  write data.
- bus_addr_ok  in  1  request accepted this cycle.
- bus_data_ok  in  1  response returned this cycle; rdata valid.
- bus_rdata  in  DW  read data.

Behaviour:
- Reset is synchronous and active-high on clk; it is the only clock.
- Reset values:
  - state=IDLE; inst_done=0, data_done=0.
  - inst_rdata=0, data_rdata=0.
  - bus_addr, bus_wstrb, bus_wdata and bus_wr registers cleared.
  - bus_req=0.
- cpu_stall = (inst_en & ~inst_done) | (data_en & ~data_done) | (state != IDLE). Combinational.
- Done clear: at a clock edge where cpu_stall=0, inst_done and data_done clear to 0, because the pipeline advances.
- FSM states: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
- IDLE:
  - If data_en & ~data_done: go to D_ADDR.
  - Else if inst_en & ~inst_done: go to I_ADDR.
  - Data has priority; it is the older instruction.
  - On the IDLE->ADDR edge, latch bus_addr, bus_wr and bus_wstrb/bus_wdata from the selected side. Instruction requests latch wr=0 and wstrb=0.
- D_ADDR / I_ADDR:
  - bus_req=1; bus_* stay stable.
  - On bus_addr_ok, go to the matching *_DATA state.
  - A request is never withdrawn, even if the enable drops.
- D_DATA / I_DATA:
  - bus_req=0; wait for bus_data_ok.
  - On data_ok, the side's done flag is set only if its enable is still 1.
  - For reads with enable still 1, bus_rdata is latched into inst_rdata / data_rdata. Writes leave data_rdata unchanged.
  - Go to IDLE.
- A dropped enable (flush) causes the response to be discarded and the done flag to stay 0.
- bus_data_ok outside a *_DATA state is ignored.
- The bus never asserts data_ok in the same cycle as the addr_ok of the same request.
- Minimum latency, request arriving in IDLE at cycle 0:
  - bus_req at cycle 1 (addr_ok same cycle).
  - data_ok earliest at cycle 2.
  - done flag and rdata visible at cycle 3; cpu_stall low at cycle 3 if no other request is pending.
- Both sides enabled: the data transaction runs fully, then the instruction transaction. cpu_stall stays high until both done flags are set. Best case is 6 cycles.
- Held results:
  - inst_rdata/data_rdata hold their values after done until overwritten.
  - A side whose done flag is already set is not re-issued while the other side completes.
- Reset mid-transaction: return to IDLE immediately and clear the done flags. The outstanding bus transaction is abandoned; the bus shares rst.
- Addresses and data pass through unchanged. The block does no alignment checking; address errors are masked upstream by deasserting data_en.

Test Plan:
- Fetch only: inst_en=1, inst_addr=0xBFC00000; bus addr_ok immediately, data_ok one cycle later with 0x3C080001 -> bus_req high for 1 cycle with bus_addr=0xBFC00000 and bus_wr=0; inst_rdata=0x3C080001 at cycle 3; cpu_stall high for cycles 0-2 and low at cycle 3.
- Simultaneous load and fetch: data_addr=0x80001000 with data_wen=0, inst_addr=0xBFC00004 -> data request issued first, fetch second; data_rdata and inst_rdata both correct; cpu_stall held high until both complete, then drops for 1 cycle and both done flags clear.
- Store: data_wen=4'b0011, data_wdata=0x0000BEEF, addr=0x80002000; bus holds addr_ok=0 for 3 cycles -> bus_req, bus_wr=1 and bus_wstrb=0011 stay stable across all 4 cycles; data_rdata is unchanged after completion.
- Flush mid-flight: data_en drops during D_DATA, then data_ok arrives with 0xDEADBEEF -> data_rdata is not updated and data_done stays 0; FSM returns to IDLE and services the pending fetch.
- Reset while in I_DATA: rst=1 for one cycle -> state=IDLE, cpu_stall follows the enables only, bus_req=0; a stray data_ok arriving afterwards is ignored.
- Back-to-back fetches: cpu_stall deasserts and inst_addr advances by 4 -> a new I_ADDR is entered on the next cycle; no fetch is duplicated and none is skipped.
